// File: rtl/stage_id_pipe.sv
// Decode stage with 2R1W regfile, write-back bypass, load-use stall and registered ID/EX output.
// Define STAGE_ID_CSR_EN to add the CSR/privileged-return outputs; otherwise SYSTEM decodes as illegal.
module stage_id_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int HAZ_EN = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_func,
`ifdef STAGE_ID_CSR_EN
  output logic [1:0]      out_csr_op,
  output logic [1:0]      out_priv_ret,
  output logic [11:0]     out_csr_addr,
`endif
  // {illegal, br, br_addr_mode, mem_read, mem_write, mem2reg, regs_write, alu_src2[1:0], alu_src1[1:0], alu_op[2:0]}
  output logic [13:0]     out_ctrl
);

  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NR      = 6'(NREGS);
  localparam int         C_MEMRD = 10;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                         OP_BR = 7'h63, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_SYS = 7'h73;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1_f, rs2_f, rd_f, rs1_idx, rs2_idx, rd_idx;
  logic       rs1_used, rs2_used, rd_used, legal, bad_reg, illegal;
  logic       br, br_mode, mrd, mwr, m2r, rw;
  logic [1:0] src1, src2;
  logic [2:0] aop;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;
  logic [13:0] ctrl_d;
  logic       wb_we, hazard, accept;
  logic [XLEN-1:0] rf [NREGS];

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign rs1_f = in_inst[19:15];
  assign rs2_f = in_inst[24:20];
  assign rd_f  = in_inst[11:7];

  always_comb begin
    rs1_used = 1'b1; rs2_used = 1'b0; rd_used = 1'b1; legal = 1'b1;
    br = 1'b0; br_mode = 1'b0; mrd = 1'b0; mwr = 1'b0; m2r = 1'b0; rw = 1'b0;
    src1 = 2'b00; src2 = 2'b00; aop = 3'b000; imm = '0;
    // alu_src1: 00 rs1, 01 pc, 10 zero; alu_src2: 00 rs2, 01 imm, 10 const 4
    case (opc)
      OP_R:     begin rs2_used = 1'b1; rw = 1'b1; aop = 3'b010; end
      OP_I:     begin rw = 1'b1; src2 = 2'b01; aop = 3'b011; imm = XLEN'($signed(in_inst[31:20])); end
      OP_LD:    begin mrd = 1'b1; m2r = 1'b1; rw = 1'b1; src2 = 2'b01;
                      imm = XLEN'($signed(in_inst[31:20])); end
      OP_ST:    begin rs2_used = 1'b1; rd_used = 1'b0; mwr = 1'b1; src2 = 2'b01;
                      imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]})); end
      OP_BR:    begin rs2_used = 1'b1; rd_used = 1'b0; br = 1'b1; aop = 3'b001;
                      imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0})); end
      OP_JAL:   begin rs1_used = 1'b0; br = 1'b1; rw = 1'b1; src1 = 2'b01; src2 = 2'b10;
                      imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0})); end
      OP_JALR:  begin br = 1'b1; br_mode = 1'b1; rw = 1'b1; src1 = 2'b01; src2 = 2'b10;
                      imm = XLEN'($signed(in_inst[31:20])); end
      OP_LUI:   begin rs1_used = 1'b0; rw = 1'b1; src1 = 2'b10; src2 = 2'b01;
                      imm = XLEN'($signed({in_inst[31:12], 12'b0})); end
      OP_AUIPC: begin rs1_used = 1'b0; rw = 1'b1; src1 = 2'b01; src2 = 2'b01;
                      imm = XLEN'($signed({in_inst[31:12], 12'b0})); end
`ifdef STAGE_ID_CSR_EN
      OP_SYS:   begin rw = (f3 != 3'b000); imm = XLEN'($signed(in_inst[31:20])); end
`endif
      default:  legal = 1'b0;
    endcase
  end

  assign bad_reg = (rs1_used & ({1'b0, rs1_f} >= NR)) | (rs2_used & ({1'b0, rs2_f} >= NR)) |
                   (rd_used & ({1'b0, rd_f} >= NR));
  assign illegal = ~legal | bad_reg;
  assign ctrl_d  = illegal ? 14'h2000 : {1'b0, br, br_mode, mrd, mwr, m2r, rw, src2, src1, aop};
  assign rs1_idx = rs1_used ? rs1_f : 5'd0;
  assign rs2_idx = rs2_used ? rs2_f : 5'd0;
  assign rd_idx  = rd_used  ? rd_f  : 5'd0;

  assign wb_we = wb_en & (wb_addr != 5'd0) & ({1'b0, wb_addr} < NR);

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || {1'b0, idx} >= NR) return '0;
    if (wb_we && wb_addr == idx) return wb_data;
    return rf[idx[AW-1:0]];
  endfunction

  assign rs1_data = rf_read(rs1_idx);
  assign rs2_data = rf_read(rs2_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // The load in ID/EX cannot forward to a dependent instruction still in decode.
  assign hazard = (HAZ_EN != 0) & out_valid & out_ctrl[C_MEMRD] & (out_rd != 5'd0) &
                  ((rs1_used & (rs1_f == out_rd)) | (rs2_used & (rs2_f == out_rd)));
  assign in_ready = flush | ((~out_valid | out_ready) & ~hazard);
  assign accept   = in_valid & in_ready & ~flush;

`ifdef STAGE_ID_CSR_EN
  logic [1:0] csr_op_d, priv_ret_d;
  always_comb begin
    csr_op_d = 2'b00;
    if (opc == OP_SYS) begin
      if (f3 == 3'b001)      csr_op_d = 2'b01;
      else if (f3 == 3'b010) csr_op_d = 2'b10;
    end
    priv_ret_d = (in_inst == 32'h3020_0073) ? 2'b01 :
                 (in_inst == 32'h1020_0073) ? 2'b10 : 2'b00;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0; out_pc <= '0; out_rs1_data <= '0; out_rs2_data <= '0; out_imm <= '0;
      out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0; out_func <= '0; out_ctrl <= '0;
`ifdef STAGE_ID_CSR_EN
      out_csr_op <= '0; out_priv_ret <= '0; out_csr_addr <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= imm;
      out_rs1      <= rs1_idx;
      out_rs2      <= rs2_idx;
      out_rd       <= rd_idx;
      out_func     <= {in_inst[30], f3};
      out_ctrl     <= ctrl_d;
`ifdef STAGE_ID_CSR_EN
      out_csr_op   <= csr_op_d;
      out_priv_ret <= priv_ret_d;
      out_csr_addr <= in_inst[31:20];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
module tb_stage_id_pipe;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;

  logic        in_ready, out_valid, in_ready_16, out_valid_16;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [31:0] out_pc_16, out_rs1_data_16, out_rs2_data_16, out_imm_16;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_rs1_16, out_rs2_16, out_rd_16;
  logic [3:0]  out_func, out_func_16;
  logic [13:0] out_ctrl, out_ctrl_16;
`ifdef STAGE_ID_CSR_EN
  logic [1:0]  csr_op, priv_ret, csr_op_16, priv_ret_16;
  logic [11:0] csr_addr, csr_addr_16;
`endif

  int n_vec = 0, n_err = 0;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [13:0] ctrl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  initial begin
    #20000;
    n_err++;
    $error("FAIL timeout: directed sequence did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  stage_id_pipe #(.XLEN(32), .NREGS(32), .HAZ_EN(1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_func(out_func),
`ifdef STAGE_ID_CSR_EN
    .out_csr_op(csr_op), .out_priv_ret(priv_ret), .out_csr_addr(csr_addr),
`endif
    .out_ctrl(out_ctrl));

  stage_id_pipe #(.XLEN(32), .NREGS(16), .HAZ_EN(1)) u_dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_16), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid_16), .out_ready(out_ready), .out_pc(out_pc_16),
    .out_rs1_data(out_rs1_data_16), .out_rs2_data(out_rs2_data_16), .out_imm(out_imm_16),
    .out_rs1(out_rs1_16), .out_rs2(out_rs2_16), .out_rd(out_rd_16), .out_func(out_func_16),
`ifdef STAGE_ID_CSR_EN
    .out_csr_op(csr_op_16), .out_priv_ret(priv_ret_16), .out_csr_addr(csr_addr_16),
`endif
    .out_ctrl(out_ctrl_16));

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, rs1, rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_err++;
    $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] pc, rs1d, rs2d, imm, input logic [4:0] rs1, rs2, rd,
                      input logic [3:0] func, input logic [13:0] ctrl);
    exp_t e;
    e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.func = func; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (out_valid && flush) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (out_valid && out_ready) begin
      n_vec++; if (sb.size() == 0) fail("sb_nonempty", 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++; if (out_pc !== e.pc) fail("pc", out_pc, e.pc);
        n_vec++; if (out_rs1_data !== e.rs1d) fail("rs1_data", out_rs1_data, e.rs1d);
        n_vec++; if (out_rs2_data !== e.rs2d) fail("rs2_data", out_rs2_data, e.rs2d);
        n_vec++; if (out_imm !== e.imm) fail("imm", out_imm, e.imm);
        n_vec++; if (out_rs1 !== e.rs1) fail("rs1", out_rs1, e.rs1);
        n_vec++; if (out_rs2 !== e.rs2) fail("rs2", out_rs2, e.rs2);
        n_vec++; if (out_rd !== e.rd) fail("rd", out_rd, e.rd);
        n_vec++; if (out_func !== e.func) fail("func", out_func, e.func);
        n_vec++; if (out_ctrl !== e.ctrl) fail("ctrl", out_ctrl, e.ctrl);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    #1;
  endtask

  initial begin
    tick(); tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_ctrl !== 14'h0 || out_valid_16 !== 1'b0) begin
      n_err++;
      $error("FAIL reset state: out_valid=%0b out_ctrl=%0h out_valid16=%0b",
             out_valid, out_ctrl, out_valid_16);
    end
    n_vec++; if (in_ready !== 1'b1) fail("rst_in_ready", in_ready, 1);
    rstn = 1'b1;

    drive(enc_r(5'd0, 5'd5, 5'd6), 32'h100);
    n_vec++; if (in_ready !== 1'b1) fail("in_ready_idle", in_ready, 1);
    push(32'h100, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 4'h0, 14'h082);
    tick();
    n_vec++; if (out_valid !== 1'b1) fail("out_valid_first", out_valid, 1);

    drive(enc_r(5'd0, 5'd3, 5'd1), 32'h104);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    push(32'h104, 32'hDEADBEEF, 32'h0, 32'h0, 5'd3, 5'd0, 5'd1, 4'h0, 14'h082);
    tick();

    drive(enc_i(12'hFFF, 5'd3, 3'b000, 5'd7, 7'h13), 32'h108);
    wb_addr = 5'd2; wb_data = 32'h0000_1234;
    push(32'h108, 32'hDEADBEEF, 32'h0, 32'hFFFF_FFFF, 5'd3, 5'd0, 5'd7, 4'h8, 14'h0A3);
    tick();
    wb_en = 1'b0;

    drive(enc_i(12'h000, 5'd1, 3'b010, 5'd2, 7'h03), 32'h10C);
    push(32'h10C, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 4'h2, 14'h5A0);
    tick();
    drive(enc_r(5'd2, 5'd2, 5'd4), 32'h110);
    n_vec++; if (in_ready !== 1'b0) fail("lu_in_ready_stall", in_ready, 0);
    tick();
    n_vec++; if (out_valid !== 1'b0) fail("lu_bubble", out_valid, 0);
    n_vec++; if (in_ready !== 1'b1) fail("lu_in_ready_after", in_ready, 1);
    push(32'h110, 32'h1234, 32'h1234, 32'h0, 5'd2, 5'd2, 5'd4, 4'h0, 14'h082);
    tick();
    n_vec++; if (out_valid !== 1'b1) fail("lu_issue", out_valid, 1);

    drive(enc_i(12'h000, 5'd1, 3'b010, 5'd0, 7'h03), 32'h114);
    push(32'h114, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 4'h2, 14'h5A0);
    tick();
    drive(enc_r(5'd0, 5'd0, 5'd4), 32'h118);
    n_vec++; if (in_ready !== 1'b1) fail("x0_no_stall", in_ready, 1);
    push(32'h118, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 4'h0, 14'h082);
    tick();
    n_vec++; if (out_valid !== 1'b1) fail("x0_out_valid", out_valid, 1);

    drive(enc_i(12'h000, 5'd1, 3'b010, 5'd2, 7'h03), 32'h11C);
    push(32'h11C, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 4'h2, 14'h5A0);
    tick();
    drive(enc_s(12'h004, 5'd2, 5'd5), 32'h120);
    n_vec++; if (in_ready !== 1'b0) fail("st_rs2_stall", in_ready, 0);
    tick();
    n_vec++; if (out_valid !== 1'b0) fail("st_bubble", out_valid, 0);
    push(32'h120, 32'h0, 32'h1234, 32'h4, 5'd5, 5'd2, 5'd0, 4'h2, 14'h220);
    tick();

    out_ready = 1'b0;
    drive(enc_i(12'h001, 5'd5, 3'b000, 5'd9, 7'h13), 32'h124);
    n_vec++; if (in_ready !== 1'b0) fail("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b1) fail("bp_valid", out_valid, 1);
      n_vec++; if (out_pc !== 32'h120) fail("bp_pc", out_pc, 32'h120);
      n_vec++; if (out_imm !== 32'h4) fail("bp_imm", out_imm, 32'h4);
      n_vec++; if (in_ready !== 1'b0) fail("bp_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) fail("bp_release_ready", in_ready, 1);
    push(32'h124, 32'h0, 32'h0, 32'h1, 5'd5, 5'd0, 5'd9, 4'h0, 14'h0A3);
    tick();
    n_vec++; if (out_pc !== 32'h124) fail("bp_next_pc", out_pc, 32'h124);

    out_ready = 1'b0; flush = 1'b1;
    drive(enc_r(5'd1, 5'd1, 5'd1), 32'h128);
    n_vec++; if (in_ready !== 1'b1) fail("flush_in_ready", in_ready, 1);
    tick();
    n_vec++; if (out_valid !== 1'b0) fail("flush_out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (sb.size() != 0) fail("flush_sb_empty", sb.size(), 0);

    drive(enc_i(12'h000, 5'd3, 3'b000, 5'd8, 7'h13), 32'h12C);
    tick();
    n_vec++; if (out_valid !== 1'b1) fail("pre_rst_valid", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) fail("arst_valid", out_valid, 0);
    n_vec++; if (out_pc !== 32'h0) fail("arst_pc", out_pc, 0);
    n_vec++; if (out_ctrl !== 14'h0) fail("arst_ctrl", out_ctrl, 0);
    sb.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b1;
    drive(enc_i(12'h000, 5'd3, 3'b000, 5'd8, 7'h13), 32'h130);
    push(32'h130, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 4'h0, 14'h0A3);
    tick();

    drive(enc_r(5'd2, 5'd1, 5'd17), 32'h134);
    push(32'h134, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd17, 4'h0, 14'h082);
    tick();
    n_vec++; if (out_valid_16 !== 1'b1) fail("rv32e_valid", out_valid_16, 1);
    n_vec++; if (out_ctrl_16 !== 14'h2000) fail("rv32e_ctrl_illegal", out_ctrl_16, 14'h2000);
    n_vec++; if (out_rd_16 !== 5'd17) fail("rv32e_rd", out_rd_16, 17);

    drive(32'h0000_007F, 32'h138);
    push(32'h138, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 14'h2000);
    tick();
    drive(32'h3020_0073, 32'h13C);
`ifdef STAGE_ID_CSR_EN
    push(32'h13C, 32'h0, 32'h0, 32'h302, 5'd0, 5'd0, 5'd0, 4'h0, 14'h0000);
`else
    push(32'h13C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 14'h2000);
`endif
    tick();
`ifdef STAGE_ID_CSR_EN
    n_vec++; if (priv_ret !== 2'b01) fail("mret_priv_ret", priv_ret, 1);
    n_vec++; if (csr_addr !== 12'h302) fail("mret_csr_addr", csr_addr, 12'h302);
`endif

    in_valid = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) fail("drain_out_valid", out_valid, 0);
    n_vec++; if (sb.size() != 0) fail("drain_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
